// File: rtl/mem_arbiter.sv
// Two-master (CPU m0, DMA m1) round-robin arbiter onto one shared slave bus.
// Optional slave-response timeout enabled by defining MEM_ARBITER_TIMEOUT_EN.
module mem_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_valid,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic        m0_ready,
   output logic [31:0] m0_rdata,
   input  logic        m1_valid,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic        m1_ready,
   output logic [31:0] m1_rdata,
   output logic        s_valid,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wstrb,
   input  logic        s_ready,
   input  logic [31:0] s_rdata,
   output logic [1:0]  owner,
   output logic        timeout_flag
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_t;

   state_t      r_state;
   logic        r_last_m1;
   logic [1:0]  r_owner;
   logic        w_own_valid;
   logic        w_done;
   logic        w_timeout;

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("mem_arbiter: TIMEOUT_CYCLES out of range 2..65535");
   end

`ifdef MEM_ARBITER_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] r_tcnt;
   logic        r_timeout_flag;

   assign w_timeout    = (r_state != IDLE) & w_own_valid & ~s_ready & (r_tcnt == TO_LAST);
   assign timeout_flag = r_timeout_flag;

   // Cycles spent in the current grant without a slave response; cleared while idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tcnt         <= 16'd0;
         r_timeout_flag <= 1'b0;
      end else begin
         if (r_state == IDLE) begin
            r_tcnt <= 16'd0;
         end else if (!s_ready) begin
            r_tcnt <= r_tcnt + 16'd1;
         end else begin
            r_tcnt <= r_tcnt;
         end
         r_timeout_flag <= r_timeout_flag | w_timeout;
      end
   end
`else
   assign w_timeout    = 1'b0;
   assign timeout_flag = 1'b0;
`endif

   assign w_done = w_own_valid & s_ready;
   assign owner  = r_owner;

   // Slave-side mux and ready/rdata return paths.
   always_comb begin
      w_own_valid = 1'b0;
      s_addr      = 32'd0;
      s_wdata     = 32'd0;
      s_wstrb     = 4'd0;
      case (r_state)
         GRANT0: begin
            w_own_valid = m0_valid;
            s_addr      = m0_addr;
            s_wdata     = m0_wdata;
            s_wstrb     = m0_wstrb;
         end
         GRANT1: begin
            w_own_valid = m1_valid;
            s_addr      = m1_addr;
            s_wdata     = m1_wdata;
            s_wstrb     = m1_wstrb;
         end
         default: begin
            w_own_valid = 1'b0;
         end
      endcase
      // A timeout completes the transfer locally, so the slave must not see it.
      s_valid  = w_own_valid & ~w_timeout;
      m0_ready = (r_state == GRANT0) & (w_done | w_timeout);
      m1_ready = (r_state == GRANT1) & (w_done | w_timeout);
      m0_rdata = s_rdata;
      m1_rdata = s_rdata;
      if (w_timeout && r_state == GRANT0) begin
         m0_rdata = 32'hDEAD_BEEF;
      end else if (w_timeout && r_state == GRANT1) begin
         m1_rdata = 32'hDEAD_BEEF;
      end else begin
         m0_rdata = s_rdata;
      end
   end

   // Grant FSM with round-robin pointer and registered one-hot owner.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_last_m1 <= 1'b1;
         r_owner   <= 2'b00;
      end else begin
         case (r_state)
            IDLE: begin
               if (m0_valid && (!m1_valid || r_last_m1)) begin
                  r_state <= GRANT0;
                  r_owner <= 2'b01;
               end else if (m1_valid) begin
                  r_state <= GRANT1;
                  r_owner <= 2'b10;
               end else begin
                  r_state <= IDLE;
                  r_owner <= 2'b00;
               end
            end
            GRANT0: begin
               if (w_done || w_timeout) begin
                  r_state   <= IDLE;
                  r_owner   <= 2'b00;
                  r_last_m1 <= 1'b0;
               end else if (!m0_valid) begin
                  r_state <= IDLE;
                  r_owner <= 2'b00;
               end else begin
                  r_state <= GRANT0;
               end
            end
            GRANT1: begin
               if (w_done || w_timeout) begin
                  r_state   <= IDLE;
                  r_owner   <= 2'b00;
                  r_last_m1 <= 1'b1;
               end else if (!m1_valid) begin
                  r_state <= IDLE;
                  r_owner <= 2'b00;
               end else begin
                  r_state <= GRANT1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_owner <= 2'b00;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (TIMEOUT_CYCLES = 8).
module tb_mem_arbiter;

   logic        clk, reset;
   logic        m0_valid, m1_valid, m0_ready, m1_ready, s_valid, s_ready, timeout_flag;
   logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
   logic [1:0]  owner;
   int          n_pass = 0;
   int          n_total = 0;

   mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .reset(reset),
      .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
      .m0_ready(m0_ready), .m0_rdata(m0_rdata),
      .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
      .m1_ready(m1_ready), .m1_rdata(m1_rdata),
      .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
      .s_ready(s_ready), .s_rdata(s_rdata),
      .owner(owner), .timeout_flag(timeout_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; s_ready = 1'b0; s_rdata = 32'd0;
      m0_valid = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0; m0_wstrb = 4'd0;
      m1_valid = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0; m1_wstrb = 4'd0;
      #2;
      n_total++; if (owner !== 2'b00) $display("FAIL reset_owner: got %b expected 00", owner); else n_pass++;
      n_total++; if (s_valid !== 1'b0) $display("FAIL reset_svalid: got %b expected 0", s_valid); else n_pass++;
      n_total++; if (s_addr !== 32'd0) $display("FAIL reset_saddr: got %h expected 0", s_addr); else n_pass++;
      n_total++; if ({m0_ready, m1_ready} !== 2'b00) $display("FAIL reset_ready: got %b expected 00", {m0_ready, m1_ready}); else n_pass++;
      n_total++; if (timeout_flag !== 1'b0) $display("FAIL reset_tflag: got %b expected 0", timeout_flag); else n_pass++;
      step();
      reset = 1'b0;
   endtask

   task automatic test_single_read();
      step();
      m0_valid = 1'b1; m0_addr = 32'h0000_0010; m0_wstrb = 4'h0;
      @(negedge clk);
      n_total++; if (s_valid !== 1'b0) $display("FAIL read_idle_svalid: got %b expected 0", s_valid); else n_pass++;
      @(posedge clk); @(negedge clk);
      n_total++; if (owner !== 2'b01) $display("FAIL read_owner: got %b expected 01", owner); else n_pass++;
      n_total++; if (s_valid !== 1'b1 || s_addr !== 32'h10) $display("FAIL read_sbus: got v=%b a=%h expected v=1 a=00000010", s_valid, s_addr); else n_pass++;
      n_total++; if (m0_ready !== 1'b0) $display("FAIL read_early_ready: got %b expected 0", m0_ready); else n_pass++;
      step(); step();
      s_ready = 1'b1; s_rdata = 32'h1234_5678;
      @(negedge clk);
      n_total++; if (m0_ready !== 1'b1 || m0_rdata !== 32'h1234_5678) $display("FAIL read_done: got r=%b d=%h expected r=1 d=12345678", m0_ready, m0_rdata); else n_pass++;
      step();
      m0_valid = 1'b0; s_ready = 1'b0;
      @(negedge clk);
      n_total++; if (owner !== 2'b00 || m0_ready !== 1'b0) $display("FAIL read_back_idle: got o=%b r=%b expected o=00 r=0", owner, m0_ready); else n_pass++;
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_own;
      reset = 1'b1; #2; reset = 1'b0;
      step();
      m0_valid = 1'b1; m0_addr = 32'h0000_0100; m1_valid = 1'b1; m1_addr = 32'h0000_0200;
      s_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         exp_own = (i % 2 == 0) ? 2'b01 : 2'b10;
         @(posedge clk); @(negedge clk);
         n_total++; if (owner !== exp_own) $display("FAIL rr_owner_%0d: got %b expected %b", i, owner, exp_own); else n_pass++;
         n_total++; if ({m1_ready, m0_ready} !== exp_own) $display("FAIL rr_ready_%0d: got %b expected %b", i, {m1_ready, m0_ready}, exp_own); else n_pass++;
         n_total++; if (s_addr !== ((i % 2 == 0) ? 32'h100 : 32'h200)) $display("FAIL rr_addr_%0d: got %h", i, s_addr); else n_pass++;
         step();
         if (i == 5) begin
            m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
         end
         @(negedge clk);
         n_total++; if (owner !== 2'b00) $display("FAIL rr_idle_%0d: got %b expected 00", i, owner); else n_pass++;
      end
   endtask

   task automatic test_back_to_back_hold();
      m1_valid = 1'b1; m1_addr = 32'h0002_0004; m1_wdata = 32'hA5A5_A5A5; m1_wstrb = 4'hF;
      step();
      step();
      m0_valid = 1'b1; m0_addr = 32'h0000_0030; m0_wstrb = 4'h0;
      @(negedge clk);
      n_total++; if (owner !== 2'b10) $display("FAIL hold_owner: got %b expected 10", owner); else n_pass++;
      n_total++; if (s_addr !== 32'h0002_0004 || s_wdata !== 32'hA5A5_A5A5 || s_wstrb !== 4'hF) $display("FAIL hold_fields: got a=%h d=%h s=%h", s_addr, s_wdata, s_wstrb); else n_pass++;
      step();
      s_ready = 1'b1;
      @(negedge clk);
      n_total++; if (m1_ready !== 1'b1 || m0_ready !== 1'b0 || s_addr !== 32'h0002_0004) $display("FAIL hold_done: got r1=%b r0=%b a=%h", m1_ready, m0_ready, s_addr); else n_pass++;
      step();
      m1_valid = 1'b0; s_ready = 1'b0;
      @(negedge clk);
      n_total++; if (owner !== 2'b00) $display("FAIL hold_idle: got %b expected 00", owner); else n_pass++;
      @(posedge clk); @(negedge clk);
      n_total++; if (owner !== 2'b01 || s_addr !== 32'h30) $display("FAIL hold_m0_grant: got o=%b a=%h expected o=01 a=00000030", owner, s_addr); else n_pass++;
      step();
      s_ready = 1'b1;
      step();
      m0_valid = 1'b0; s_ready = 1'b0;
   endtask

   task automatic test_abandon();
      m1_valid = 1'b1; s_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      n_total++; if (m1_ready !== 1'b1) $display("FAIL ab_m1_done: got %b expected 1", m1_ready); else n_pass++;
      step();
      m1_valid = 1'b0; s_ready = 1'b0; m0_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      n_total++; if (owner !== 2'b01) $display("FAIL ab_grant0: got %b expected 01", owner); else n_pass++;
      step();
      m0_valid = 1'b0;
      @(negedge clk);
      n_total++; if (s_valid !== 1'b0 || m0_ready !== 1'b0) $display("FAIL ab_drop: got v=%b r=%b expected 0 0", s_valid, m0_ready); else n_pass++;
      step();
      m0_valid = 1'b1; m1_valid = 1'b1; s_ready = 1'b1;
      @(negedge clk);
      n_total++; if (owner !== 2'b00 || m0_ready !== 1'b0) $display("FAIL ab_idle: got o=%b r=%b expected 00 0", owner, m0_ready); else n_pass++;
      @(posedge clk); @(negedge clk);
      n_total++; if (owner !== 2'b01 || m0_ready !== 1'b1 || m1_ready !== 1'b0) $display("FAIL ab_tie: got o=%b r0=%b r1=%b expected 01 1 0", owner, m0_ready, m1_ready); else n_pass++;
      step();
      m0_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      n_total++; if (owner !== 2'b10 || m1_ready !== 1'b1) $display("FAIL ab_m1_after: got o=%b r=%b expected 10 1", owner, m1_ready); else n_pass++;
      step();
      m1_valid = 1'b0; s_ready = 1'b0;
   endtask

   task automatic test_timeout();
      m0_valid = 1'b1; m0_addr = 32'h0000_0040; s_ready = 1'b0; s_rdata = 32'h0000_0055;
`ifdef MEM_ARBITER_TIMEOUT_EN
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); @(negedge clk);
         if (k < 8) begin
            n_total++; if (m0_ready !== 1'b0 || owner !== 2'b01) $display("FAIL to_wait_%0d: got r=%b o=%b expected 0 01", k, m0_ready, owner); else n_pass++;
         end else begin
            n_total++; if (m0_ready !== 1'b1 || m0_rdata !== 32'hDEAD_BEEF || s_valid !== 1'b0) $display("FAIL to_fire: got r=%b d=%h v=%b expected 1 deadbeef 0", m0_ready, m0_rdata, s_valid); else n_pass++;
         end
      end
      step();
      m0_valid = 1'b0;
      @(negedge clk);
      n_total++; if (owner !== 2'b00 || timeout_flag !== 1'b1) $display("FAIL to_flag: got o=%b f=%b expected 00 1", owner, timeout_flag); else n_pass++;
      step();
      m0_valid = 1'b1; s_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      n_total++; if (m0_ready !== 1'b1 || m0_rdata !== 32'h55 || timeout_flag !== 1'b1) $display("FAIL to_next: got r=%b d=%h f=%b expected 1 00000055 1", m0_ready, m0_rdata, timeout_flag); else n_pass++;
`else
      for (int k = 0; k < 20; k++) @(posedge clk);
      @(negedge clk);
      n_total++; if (owner !== 2'b01 || m0_ready !== 1'b0 || timeout_flag !== 1'b0) $display("FAIL nto_wait: got o=%b r=%b f=%b expected 01 0 0", owner, m0_ready, timeout_flag); else n_pass++;
      step();
      s_ready = 1'b1;
      @(negedge clk);
      n_total++; if (m0_ready !== 1'b1 || m0_rdata !== 32'h55) $display("FAIL nto_done: got r=%b d=%h expected 1 00000055", m0_ready, m0_rdata); else n_pass++;
`endif
      step();
      m0_valid = 1'b0; s_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      m1_valid = 1'b1; m1_addr = 32'h0000_0080;
      @(posedge clk); @(negedge clk);
      n_total++; if (owner !== 2'b10 || s_valid !== 1'b1) $display("FAIL rm_grant1: got o=%b v=%b expected 10 1", owner, s_valid); else n_pass++;
      #2;
      reset = 1'b1;
      #1;
      n_total++; if (owner !== 2'b00 || s_valid !== 1'b0 || m1_ready !== 1'b0) $display("FAIL rm_async: got o=%b v=%b r=%b expected 00 0 0", owner, s_valid, m1_ready); else n_pass++;
      step();
      reset = 1'b0; m0_valid = 1'b1; s_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      n_total++; if (owner !== 2'b01 || m0_ready !== 1'b1 || m1_ready !== 1'b0) $display("FAIL rm_tie: got o=%b r0=%b r1=%b expected 01 1 0", owner, m0_ready, m1_ready); else n_pass++;
      step();
      m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_round_robin();
      test_back_to_back_hold();
      test_abandon();
      test_timeout();
      test_reset_mid();
      step();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
